// File: rtl/joypad_pkg.sv
// Shared constants for the NES controller port at $4016/$4017.
package joypad_pkg;
  // Button bit positions inside a pad byte
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Bits 7:1 of a controller read show the open-bus image
  localparam logic [7:0]  OPEN_BUS = 8'h40;

  localparam logic [15:0] ADDR_P1_DEF   = 16'h4016;
  localparam logic [15:0] ADDR_P2_DEF   = 16'h4017;
  localparam logic [23:0] TURBO_DIV_DEF = 24'd833333;
endpackage

// File: rtl/joypad_shift.sv
// One controller channel: 2-flop synchronizer, 8-bit load/shift register
// and read-end edge detect. With JOYPAD_TURBO_EN an OR mask is applied
// to the synchronized buttons before loading.
module joypad_shift
  import joypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       strobe,
  input  logic       rd,
  input  logic [7:0] pad,
`ifdef JOYPAD_TURBO_EN
  input  logic [7:0] turbo_or,
`endif
  output logic       bit_out
);

  logic [7:0] pad_m, pad_s, sh, load_val;
  logic       rd_q;

`ifdef JOYPAD_TURBO_EN
  assign load_val = pad_s | turbo_or;
`else
  assign load_val = pad_s;
`endif

  // Synchronizer, access tracking and the load/shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pad_m <= 8'h00;
      pad_s <= 8'h00;
      sh    <= 8'h00;
      rd_q  <= 1'b0;
    end else begin
      pad_m <= pad;
      pad_s <= pad_m;
      rd_q  <= rd;
      // Reload beats shifting, so reads under strobe keep showing live A
      if (strobe)
        sh <= load_val;
      else if (rd_q && !rd)
        sh <= {1'b1, sh[7:1]};
    end
  end

  assign bit_out = sh[BTN_A];

endmodule

// File: rtl/joypad_port.sv
// CPU-side responder for the controller registers $4016/$4017.
// Optional turbo buttons are enabled by defining JOYPAD_TURBO_EN.
module joypad_port
  import joypad_pkg::*;
#(
  parameter logic [15:0] ADDR_P1   = ADDR_P1_DEF,
  parameter logic [15:0] ADDR_P2   = ADDR_P2_DEF,
  parameter logic [23:0] TURBO_DIV = TURBO_DIV_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        write,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic [7:0]  pad1,
  input  logic [7:0]  pad2,
`ifdef JOYPAD_TURBO_EN
  input  logic [1:0]  pad1_turbo,
  input  logic [1:0]  pad2_turbo,
`endif
  output logic        strobe
);

  logic rd1, rd2, wr_strobe, bit1, bit2;
  logic unused_din;

  assign unused_din = ^din[7:1];
  assign rd1        = en && !write && (addr == ADDR_P1);
  assign rd2        = en && !write && (addr == ADDR_P2);
  assign wr_strobe  = en && write && (addr == ADDR_P1);

  // Strobe latch, written only through $4016
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          strobe <= 1'b0;
    else if (wr_strobe) strobe <= din[0];
  end

`ifdef JOYPAD_TURBO_EN
  logic [1:0]  t1_m, t1_s, t2_m, t2_s;
  logic [23:0] turbo_cnt;
  logic        phase;
  logic [7:0]  t1_or, t2_or;

  // Turbo synchronizers and free-running phase divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t1_m      <= 2'b00;
      t1_s      <= 2'b00;
      t2_m      <= 2'b00;
      t2_s      <= 2'b00;
      turbo_cnt <= 24'd0;
      phase     <= 1'b0;
    end else begin
      t1_m <= pad1_turbo;
      t1_s <= t1_m;
      t2_m <= pad2_turbo;
      t2_s <= t2_m;
      if (turbo_cnt == TURBO_DIV - 24'd1) begin
        turbo_cnt <= 24'd0;
        phase     <= ~phase;
      end else begin
        turbo_cnt <= turbo_cnt + 24'd1;
      end
    end
  end

  // Turbo bits only ever add presses on A/B while phase is high
  always_comb begin
    t1_or        = 8'h00;
    t2_or        = 8'h00;
    t1_or[BTN_A] = t1_s[0] & phase;
    t1_or[BTN_B] = t1_s[1] & phase;
    t2_or[BTN_A] = t2_s[0] & phase;
    t2_or[BTN_B] = t2_s[1] & phase;
  end
`endif

  joypad_shift u_p1 (
    .clk     (clk),
    .reset   (reset),
    .strobe  (strobe),
    .rd      (rd1),
    .pad     (pad1),
`ifdef JOYPAD_TURBO_EN
    .turbo_or(t1_or),
`endif
    .bit_out (bit1)
  );

  joypad_shift u_p2 (
    .clk     (clk),
    .reset   (reset),
    .strobe  (strobe),
    .rd      (rd2),
    .pad     (pad2),
`ifdef JOYPAD_TURBO_EN
    .turbo_or(t2_or),
`endif
    .bit_out (bit2)
  );

  // Read data mux; zero when this block is not being read
  always_comb begin
    dout = 8'h00;
    if (rd1)      dout = OPEN_BUS | {7'b0, bit1};
    else if (rd2) dout = OPEN_BUS | {7'b0, bit2};
  end

endmodule

// File: tb/tb_joypad_port.sv
// Scoreboard bench for joypad_port: expected read data is queued when a
// read is issued and compared when dout is sampled mid-access.
module tb_joypad_port;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0, write = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  din = 8'h00, dout;
  logic [7:0]  pad1 = 8'h00, pad2 = 8'h00;
  logic        strobe;
`ifdef JOYPAD_TURBO_EN
  logic [1:0]  pad1_turbo = 2'b00, pad2_turbo = 2'b00;
`endif

  int errors = 0, checks = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  joypad_port #(.TURBO_DIV(24'd4)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .write     (write),
    .addr      (addr),
    .din       (din),
    .dout      (dout),
    .pad1      (pad1),
    .pad2      (pad2),
`ifdef JOYPAD_TURBO_EN
    .pad1_turbo(pad1_turbo),
    .pad2_turbo(pad2_turbo),
`endif
    .strobe    (strobe)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    en = 1'b1; write = 1'b1; addr = a; din = d;
    @(posedge clk); #1;
    en = 1'b0; write = 1'b0;
  endtask

  // One 16-clk read access; dout sampled in the middle
  task automatic bus_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] got;
    @(posedge clk); #1;
    en = 1'b1; write = 1'b0; addr = a;
    exp_q.push_back(exp);
    repeat (8) @(posedge clk);
    @(negedge clk);
    got = dout;
    if (exp_q.size() == 0) chk({tag, "_noexp"}, got, 8'hxx);
    else chk(tag, got, exp_q.pop_front());
    repeat (8) @(posedge clk);
    #1 en = 1'b0;
  endtask

  initial begin
    logic [7:0] seq_exp [10];
    seq_exp = '{8'h41, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41, 8'h41};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_strobe", {7'b0, strobe}, 8'h00);
    chk("rst_dout", dout, 8'h00);
    #1 reset = 1'b0;

    // Reset in the middle of an open read
    bus_write(16'h4016, 8'h01);
    @(posedge clk); #1;
    en = 1'b1; addr = 16'h4016;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_strobe", {7'b0, strobe}, 8'h00);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 en = 1'b0;
    bus_read("midrst_rd", 16'h4016, 8'h40);

    // Latch then serial sequence including 1-fill
    pad1 = 8'b1000_0101;
    repeat (3) @(posedge clk);
    bus_write(16'h4016, 8'h01);
    bus_write(16'h4016, 8'h00);
    for (int i = 0; i < 10; i++) bus_read($sformatf("seq%0d", i), 16'h4016, seq_exp[i]);

    // Writes to $4017 do not touch the strobe
    bus_write(16'h4017, 8'h01);
    @(negedge clk);
    chk("wr4017_strobe", {7'b0, strobe}, 8'h00);
    chk("idle_dout", dout, 8'h00);

    // Strobe held: reads return live A without shifting
    pad1 = 8'h01;
    bus_write(16'h4016, 8'h01);
    repeat (3) @(posedge clk);
    for (int i = 0; i < 3; i++) bus_read($sformatf("held%0d", i), 16'h4016, 8'h41);
    pad1 = 8'h00;
    repeat (3) @(posedge clk);
    bus_read("held_drop", 16'h4016, 8'h40);
    bus_write(16'h4016, 8'h00);

    // Port independence
    pad1 = 8'h00; pad2 = 8'h02;
    repeat (3) @(posedge clk);
    bus_write(16'h4016, 8'h01);
    bus_write(16'h4016, 8'h00);
    bus_read("p2_a", 16'h4017, 8'h40);
    bus_read("p2_b", 16'h4017, 8'h41);
    bus_read("p1_a", 16'h4016, 8'h40);

    // Pad change one clk before strobe falls: old value latched
    pad1 = 8'h01;
    bus_write(16'h4016, 8'h01);
    repeat (4) @(posedge clk);
    @(posedge clk); #1;
    pad1 = 8'h00;
    en = 1'b1; write = 1'b1; addr = 16'h4016; din = 8'h00;
    @(posedge clk); #1;
    en = 1'b0; write = 1'b0;
    bus_read("sync_old", 16'h4016, 8'h41);

    // Pad change three clks before strobe falls: new value latched
    pad1 = 8'h01;
    bus_write(16'h4016, 8'h01);
    repeat (4) @(posedge clk);
    @(posedge clk); #1 pad1 = 8'h00;
    @(posedge clk);
    @(posedge clk); #1;
    en = 1'b1; write = 1'b1; addr = 16'h4016; din = 8'h00;
    @(posedge clk); #1;
    en = 1'b0; write = 1'b0;
    bus_read("sync_new", 16'h4016, 8'h40);

`ifdef JOYPAD_TURBO_EN
    begin
      logic [15:0] s;
      int ones, diffs;
      pad1 = 8'h00; pad1_turbo = 2'b01;
      bus_write(16'h4016, 8'h01);
      repeat (4) @(posedge clk);
      @(posedge clk); #1;
      en = 1'b1; addr = 16'h4016;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        s[i] = dout[0];
      end
      #1 en = 1'b0;
      ones = 0; diffs = 0;
      for (int i = 0; i < 16; i++) ones += int'(s[i]);
      for (int i = 0; i < 12; i++) diffs += int'(s[i] != s[i+4]);
      chk("turbo_ones", 8'(ones), 8'd8);
      chk("turbo_half", 8'(diffs), 8'd12);
    end
`endif

    if (exp_q.size() != 0) chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
